// File: rtl/cu_command_arbiter_pkg.sv
// Shared types for the CU command arbiter: FSM states, buffer line
// and status bundles, and the round-robin search helper.
package cu_command_arbiter_pkg;

  localparam int unsigned MAX_REQ  = 8;
  localparam int unsigned MAX_ID_W = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARBITRATE = 2'd1,
    STALL     = 2'd2
  } ArbState;

  typedef struct packed {
    logic        valid;
    logic [3:0]  opcode;
    logic [7:0]  tag;
    logic [31:0] address;
  } CommandBufferLine;

  typedef struct packed {
    logic [7:0] level;
    logic       full;
    logic       alfull;
    logic       empty;
  } BufferStatus;

  typedef struct packed {
    logic                found;
    logic [MAX_ID_W-1:0] idx;
  } RrSel;

  // Walk the rotated request vector from the pointer, wrapping at n.
  function automatic RrSel rr_select(
    input logic [MAX_REQ-1:0]  requests,
    input logic [MAX_ID_W-1:0] pointer,
    input int unsigned         n
  );
    RrSel        sel;
    int unsigned pos;
    sel = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      pos = 32'(pointer) + i;
      if (pos >= n) pos = pos - n;
      if (!sel.found && i < n &&
          requests[pos[MAX_ID_W-1:0]]) begin
        sel.found = 1'b1;
        sel.idx   = pos[MAX_ID_W-1:0];
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/cu_round_robin_priority.sv
// Combinational round-robin priority picker; also used by the
// response-side arbiters.
module cu_round_robin_priority
  import cu_command_arbiter_pkg::*;
#(
  parameter  int unsigned N = 4,
  localparam int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] i_requests,
  input  logic [W-1:0] i_pointer,
  output logic         o_found,
  output logic [W-1:0] o_idx
);

  RrSel w_sel;
  logic w_unused_idx;

  assign w_sel = rr_select(MAX_REQ'(i_requests),
                           MAX_ID_W'(i_pointer), N);

  assign o_found      = w_sel.found;
  assign o_idx        = w_sel.idx[W-1:0];
  assign w_unused_idx = ^w_sel.idx;

endmodule

// File: rtl/cu_command_arbiter.sv
// Round-robin arbiter sharing one command buffer between the
// command sources of a compute unit.
module cu_command_arbiter
  import cu_command_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_REQUESTS = 4,
  parameter  int unsigned COUNTER_BITS = 32,
  localparam int unsigned ID_W = $clog2(NUM_REQUESTS)
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic                    enabled_in,
  input  logic [NUM_REQUESTS-1:0] request_in,
  input  CommandBufferLine        command_in [NUM_REQUESTS],
  input  BufferStatus             command_buffer_status,
  output logic [NUM_REQUESTS-1:0] grant_out,
  output logic [ID_W-1:0]         grant_id_out,
  output CommandBufferLine        command_out,
  output logic [1:0]              arb_state_out,
  output logic [COUNTER_BITS-1:0] issued_count_out,
  output logic [COUNTER_BITS-1:0] stall_count_out
);

  ArbState                 r_state;
  ArbState                 w_next;
  logic [ID_W-1:0]         r_ptr;
  logic [NUM_REQUESTS-1:0] r_grant;
  logic [ID_W-1:0]         r_gid;
  CommandBufferLine        r_cmd;
  logic [COUNTER_BITS-1:0] r_issued;
  logic [COUNTER_BITS-1:0] r_stall;

  logic                    w_alfull;
  logic [NUM_REQUESTS-1:0] w_eligible;
  logic                    w_found;
  logic [ID_W-1:0]         w_win;
  logic [ID_W-1:0]         w_ptr_next;
  logic                    w_grant;
  logic                    w_unused_status;

  assign w_alfull = command_buffer_status.alfull;
  assign w_unused_status = ^{command_buffer_status.level,
                             command_buffer_status.full,
                             command_buffer_status.empty};

  // The last winner still shows its old command, so skip it.
  assign w_eligible = request_in & ~r_grant;

  cu_round_robin_priority #(
    .N (NUM_REQUESTS)
  ) u_rr (
    .i_requests (w_eligible),
    .i_pointer  (r_ptr),
    .o_found    (w_found),
    .o_idx      (w_win)
  );

  assign w_grant = (r_state != IDLE) && enabled_in &&
                   !w_alfull && w_found;

  assign w_ptr_next =
    (w_win == ID_W'(NUM_REQUESTS - 1)) ? '0 : w_win + 1'b1;

  always_comb begin
    w_next = r_state;
    if (!enabled_in) begin
      w_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE:      w_next = ARBITRATE;
        ARBITRATE: if (w_alfull) w_next = STALL;
        STALL:     if (!w_alfull) w_next = ARBITRATE;
        default:   w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_ptr    <= '0;
      r_grant  <= '0;
      r_gid    <= '0;
      r_cmd    <= '0;
      r_issued <= '0;
      r_stall  <= '0;
    end else begin
      r_grant <= '0;
      r_cmd   <= '0;
      if (w_grant) begin
        r_grant     <= NUM_REQUESTS'(1) << w_win;
        r_gid       <= w_win;
        r_cmd       <= command_in[w_win];
        r_cmd.valid <= 1'b1;
        r_issued    <= r_issued + 1'b1;
        r_ptr       <= w_ptr_next;
      end
      if (w_next == IDLE) r_ptr <= '0;
      if (r_state == STALL && |request_in)
        r_stall <= r_stall + 1'b1;
    end
  end

  assign grant_out        = r_grant;
  assign grant_id_out     = r_gid;
  assign command_out      = r_cmd;
  assign arb_state_out    = r_state;
  assign issued_count_out = r_issued;
  assign stall_count_out  = r_stall;

endmodule

// File: tb/tb_cu_command_arbiter.sv
// Bench for cu_command_arbiter: directed scenarios then random
// traffic, all checked against a cycle-level behavioural model.
module tb_cu_command_arbiter;
  import cu_command_arbiter_pkg::*;

  localparam int N = 4;

  logic             clock = 1'b0;
  logic             rst;
  logic             enabled_in;
  logic [N-1:0]     request_in;
  CommandBufferLine command_in [N];
  BufferStatus      status;
  logic [N-1:0]     grant_out;
  logic [1:0]       grant_id_out;
  CommandBufferLine command_out;
  logic [1:0]       arb_state_out;
  logic [31:0]      issued_count_out;
  logic [31:0]      stall_count_out;

  always #5 clock = ~clock;

  cu_command_arbiter #(
    .NUM_REQUESTS (N),
    .COUNTER_BITS (32)
  ) dut (
    .clock                 (clock),
    .rst                   (rst),
    .enabled_in            (enabled_in),
    .request_in            (request_in),
    .command_in            (command_in),
    .command_buffer_status (status),
    .grant_out             (grant_out),
    .grant_id_out          (grant_id_out),
    .command_out           (command_out),
    .arb_state_out         (arb_state_out),
    .issued_count_out      (issued_count_out),
    .stall_count_out       (stall_count_out)
  );

  int               m_state, m_ptr, m_last, m_gid;
  CommandBufferLine m_cmd;
  logic [31:0]      m_issued, m_stall;
  int               gcount [N];
  bit               rand_mode;
  int               n_pass, n_total;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic new_cmd(input int i);
    logic [63:0] r;
    r = {$urandom, $urandom};
    command_in[i] = r[$bits(CommandBufferLine)-1:0];
  endtask

  // Spec rules applied to the inputs present before the edge.
  task automatic model_edge();
    int win, s, nxt;
    if (rst) begin
      m_state = 0; m_ptr = 0; m_last = -1; m_gid = 0;
      m_cmd = '0; m_issued = 0; m_stall = 0;
      return;
    end
    win = -1;
    if (m_state != 0 && enabled_in && !status.alfull)
      for (int k = 0; k < N; k++) begin
        s = (m_ptr + k) % N;
        if (win < 0 && request_in[s] && s != m_last) win = s;
      end
    if (m_state == 2 && request_in != 0) m_stall++;
    if (!enabled_in)        nxt = 0;
    else if (status.alfull) nxt = (m_state == 0) ? 1 : 2;
    else                    nxt = 1;
    m_last = win;
    if (win >= 0) begin
      m_gid = win;
      m_cmd = command_in[win];
      m_cmd.valid = 1'b1;
      m_issued++;
      m_ptr = (win + 1) % N;
    end else begin
      m_cmd = '0;
    end
    if (nxt == 0) m_ptr = 0;
    m_state = nxt;
  endtask

  task automatic check_outputs();
    logic [63:0] eg;
    eg = (m_last >= 0) ? (64'd1 << m_last) : 64'd0;
    chk("grant", 64'(grant_out), eg);
    chk("grant_id", 64'(grant_id_out), 64'(m_gid));
    chk("command", 64'(command_out), 64'(m_cmd));
    chk("state", 64'(arb_state_out), 64'(m_state));
    chk("issued", 64'(issued_count_out), 64'(m_issued));
    chk("stall", 64'(stall_count_out), 64'(m_stall));
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    check_outputs();
    if (m_last >= 0) gcount[m_last]++;
    for (int i = 0; i < N; i++) begin
      if (m_last == i) begin
        new_cmd(i);
        if (rand_mode && $urandom_range(0, 2) == 0)
          request_in[i] = 1'b0;
      end else if (rand_mode && !request_in[i] &&
                   $urandom_range(0, 3) == 0) begin
        new_cmd(i);
        request_in[i] = 1'b1;
      end
    end
  endtask

  initial begin
    int               i0, s0, gmin, gmax;
    CommandBufferLine c2;
    logic [10:0]      sr;
    n_pass = 0; n_total = 0; rand_mode = 0;
    m_last = -1;
    rst = 1'b1; enabled_in = 1'b0;
    request_in = '0; status = '0;
    for (int i = 0; i < N; i++) new_cmd(i);

    step();
    chk("reset_grant", 64'(grant_out), 64'd0);
    chk("reset_valid", 64'(command_out.valid), 64'd0);
    rst = 1'b0;
    step();

    // Rotation
    enabled_in = 1'b1; request_in = '1;
    for (int i = 0; i < N; i++) gcount[i] = 0;
    i0 = int'(issued_count_out);
    repeat (40) step();
    chk("rot_issued_range",
        64'((int'(issued_count_out) - i0 >= 30) &&
            (int'(issued_count_out) - i0 <= 40)), 64'd1);
    gmin = gcount[0]; gmax = gcount[0];
    for (int i = 1; i < N; i++) begin
      if (gcount[i] < gmin) gmin = gcount[i];
      if (gcount[i] > gmax) gmax = gcount[i];
    end
    chk("rot_balance", 64'(gmax - gmin <= 1), 64'd1);

    // Single source
    request_in = '0;
    step();
    request_in = 4'b0100;
    i0 = int'(issued_count_out);
    c2 = command_in[2];
    c2.valid = 1'b1;
    step();
    chk("single_id", 64'(grant_id_out), 64'd2);
    chk("single_cmd", 64'(command_out), 64'(c2));
    repeat (9) step();
    chk("single_issued",
        64'(int'(issued_count_out) - i0), 64'd5);

    // Back-pressure
    request_in = 4'b0001;
    step();
    request_in = 4'b0011;
    status.alfull = 1'b1;
    s0 = int'(stall_count_out);
    repeat (5) begin
      step();
      chk("bp_no_valid", 64'(command_out.valid), 64'd0);
    end
    chk("bp_state", 64'(arb_state_out), 64'd2);
    status.alfull = 1'b0;
    step();
    // Four alfull cycles in STALL plus the release cycle.
    chk("bp_stall_count",
        64'(int'(stall_count_out) - s0), 64'd5);
    chk("bp_release_id", 64'(grant_id_out), 64'd1);

    // Disable mid-stream
    enabled_in = 1'b0;
    repeat (3) begin
      step();
      chk("dis_state", 64'(arb_state_out), 64'd0);
      chk("dis_grant", 64'(grant_out), 64'd0);
    end
    enabled_in = 1'b1;
    request_in = 4'b1000;
    step();
    step();
    chk("reen_grant", 64'(grant_out), 64'b1000);

    // Wrap from pointer 3
    request_in = 4'b0100;
    step();
    request_in = 4'b1001;
    step();
    chk("wrap_first", 64'(grant_id_out), 64'd3);
    step();
    chk("wrap_second", 64'(grant_id_out), 64'd0);

    // Synchronous reset right after a grant
    rst = 1'b1;
    step();
    chk("rst_grant", 64'(grant_out), 64'd0);
    chk("rst_issued", 64'(issued_count_out), 64'd0);
    chk("rst_state", 64'(arb_state_out), 64'd0);
    rst = 1'b0;
    request_in = 4'b0010;
    step();
    step();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    step();
    chk("glitch_issued", 64'(issued_count_out), 64'd1);
    chk("glitch_state", 64'(arb_state_out), 64'd1);

    // Random traffic
    rand_mode = 1'b1;
    repeat (600) begin
      enabled_in = ($urandom_range(0, 19) != 0);
      sr = 11'($urandom);
      status = sr;
      status.alfull = ($urandom_range(0, 4) == 0);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cu_command_arbiter.md
Name: cu_command_arbiter

Overview:
- Round-robin arbiter that shares one command buffer between NUM_REQUESTS command sources inside a compute unit. Typical sources are read, write, prefetch-read and prefetch-write engines.
- Selects one pending command per cycle, registers it onto the shared command buffer interface and returns a one-hot grant to the winner.
- Honours buffer back-pressure and the CU enable.
- Keeps issue and stall counters for the CU status path.

Parameters:
- NUM_REQUESTS, 4, number of command sources, range 2..8.
- COUNTER_BITS, 32, width of the issued and stall counters.

Ports:
- clock  in  1  single clock, rising edge.
- rst  in  1  reset: synchronous, active-high.
- enabled_in  in  1  CU enable; arbitration runs only while high.
- request_in  in  NUM_REQUESTS  per-source command-pending flag.
- command_in  in  NUM_REQUESTS x CommandBufferLine  per-source command, held stable while request is high.
- command_buffer_status  in  BufferStatus  downstream buffer status; only the alfull field is used.
- grant_out  out  NUM_REQUESTS  registered one-hot grant.
- grant_id_out  out  $clog2(NUM_REQUESTS)  index of the current grant; valid when command_out.valid is 1.
- command_out  out  CommandBufferLine  registered winning command, with valid set.
- arb_state_out  out  2  current FSM state encoding.
- issued_count_out  out  COUNTER_BITS  total commands issued.
- stall_count_out  out  COUNTER_BITS  cycles spent in STALL while a request was pending.

Behaviour:
- Reset (rst high at a rising edge): all outputs 0, state IDLE, priority pointer 0, both counters 0. A reset mid-operation drops any in-flight grant; no command is emitted on the following cycle.
- FSM states: IDLE=0, ARBITRATE=1, STALL=2.
  - IDLE -> ARBITRATE when enabled_in=1.
  - ARBITRATE -> STALL when alfull=1.
  - STALL -> ARBITRATE when alfull=0.
  - Any state -> IDLE when enabled_in=0. This has priority over every other transition.
  - Entering IDLE resets the priority pointer to 0.
- Grant condition at cycle t, evaluated combinationally on current inputs:
  - state is ARBITRATE or STALL, AND
  - enabled_in=1, AND
  - alfull=0, AND
  - eligible != 0, where eligible = request_in & ~grant_out.
- Post-grant mask: a source granted at t is excluded at t+1, because its request_in is still the stale command. Consequently a single source receives at most one grant every 2 cycles.
- Winner selection: first set bit of eligible, searching from the pointer upward and wrapping modulo NUM_REQUESTS.
- Latency: 1 cycle. At edge t+1:
  - grant_out = onehot(winner);
  - grant_id_out = winner;
  - command_out = command_in[winner] with valid=1;
  - pointer = (winner+1) mod NUM_REQUESTS, wrapping from NUM_REQUESTS-1 to 0.
- No grant at cycle t: at edge t+1 grant_out=0, command_out=0 (valid=0), grant_id_out holds its value, pointer unchanged.
- Requester contract:
  - on seeing its grant_out bit, the source advances: it drops request_in or presents the next command by the following cycle;
  - command_in must not change while request is high and the source is not granted.
- Alfull and enabled_in in the same cycle as a request: no grant.
- Counters:
  - issued_count_out increments by 1 on every emitted valid command;
  - stall_count_out increments in each cycle where state=STALL and |request_in;
  - both wrap modulo 2^COUNTER_BITS;
  - both hold their value in IDLE and clear only on rst.

Decomposition:
- Into CU_PKG:
  - ArbState enum {IDLE, ARBITRATE, STALL};
  - a function rr_select(requests, pointer) returning the winner index and a found flag.
- One natural sub-module: cu_round_robin_priority. It is combinational: rotate requests by pointer, find the first set bit, un-rotate. Reusable for the response-side arbiters.
- CommandBufferLine and BufferStatus remain as defined in CU_PKG and AFU_PKG.

Test Plan (NUM_REQUESTS=4):
- Rotation: enabled_in=1, request_in=4'b1111 held, each source re-presents on grant. Required: grant order 0,1,2,3,0... with gaps allowed only by masking. After 40 cycles, issued_count_out is between 30 and 40, and each source has an equal count ±1.
- Single source: request_in=4'b0100 held. Required: grants to 2 on alternate cycles only (mask); grant_id_out=2; command_out equals command_in[2]; after 10 cycles issued_count_out=5.
- Back-pressure: alfull=1 for 5 cycles with request_in=4'b0011. Required: arb_state_out=2, no valid command, stall_count_out=5. On release, the first grant goes to the source at the pointer.
- Disable mid-stream: enabled_in drops for 3 cycles while requests are pending. Required: state IDLE, no grants, pointer reset. On re-enable with request_in=4'b1000, the grant goes to 3.
- Synchronous reset: rst=1 in the cycle after a grant. Required: the next edge shows all outputs 0, counters 0, state IDLE. rst=1 between clock edges without an edge has no effect.
- Wrap: pointer at 3, request_in=4'b1001. Required: grant 3, then grant 0.
